disp_formatter: RTL
===================

DISP_FORMATTER -- requirements
Module: disp_formatter

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port req  input  1  CPU request strobe; accepted only when ready=1.
REQ-004 SHALL have port mode  input  2  00 number, 01 "OP", 10 "VAL", 11 "ERR".
REQ-005 SHALL have port value  input  16  signed two's-complement integer, decimal-scaled by frac.
REQ-006 SHALL have port frac  input  2  count of fractional decimal digits in value; legal values 0..2.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept req.
REQ-008 SHALL have port bin  output  8  unsigned magnitude for the display decoder.
REQ-009 SHALL have port sgn  output  1  1 means negative (minus shown on leftmost digit).
REQ-010 SHALL have port dot  output  2  0 no dot; 1 dot on tens digit (x.x); 2 dot on hundreds digit (x.xx).
REQ-011 SHALL have port msg  output  2  display message code, same encoding as mode.
REQ-012 SHALL have port wr_enable  output  1  one-cycle write strobe to the display decoder.
REQ-013 SHALL have port led0_sel  output  1  decoder select; driven identical to wr_enable.

Function
REQ-014 SHALL implement FSM states IDLE, ABS, CHECK, DIV, EMIT; ready=1 only in IDLE.
REQ-015 SHALL, in IDLE with req=1, capture mode, value and frac at that edge and go to ABS; req while not IDLE SHALL be ignored, with no queueing.
REQ-016 SHALL, in ABS, compute 16-bit unsigned magnitude |value| (-32768 -> 32768), latch sgn_int=value[15], then go to CHECK.
REQ-017 SHALL, in CHECK, go to EMIT with msg=mode, bin=0, sgn=0, dot=0 when mode!=00.
REQ-018 SHALL, in CHECK with mode=00 and frac=3, go to EMIT with msg=11, bin=0, sgn=0, dot=0.
REQ-019 SHALL, in CHECK with mode=00 and magnitude<=255, go to EMIT with msg=00, bin=magnitude[7:0], sgn=sgn_int, dot=current frac.
REQ-020 SHALL, in CHECK with magnitude>255 and frac>0, go to DIV; with magnitude>255 and frac=0, go to EMIT with msg=11, bin=0, sgn=0, dot=0.
REQ-021 SHALL, in DIV, perform a 16-iteration restoring division of magnitude by 10 (one quotient bit per cycle), discard the remainder (truncate toward zero), replace magnitude with the quotient, decrement frac by 1, and return to CHECK after the 16th cycle.
REQ-022 SHALL, in EMIT, update bin/sgn/dot/msg registers, assert wr_enable=led0_sel=1 for exactly one cycle, and return to IDLE.
REQ-023 SHALL hold bin, sgn, dot and msg stable between EMIT cycles.
REQ-024 SHALL give latency from accepting edge to wr_enable high of 2 cycles with no division, plus 17 cycles per division performed (max 2 divisions, i.e. 36 cycles).
REQ-025 SHALL never assert wr_enable outside EMIT, and SHALL assert it exactly once per accepted request.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, ready=1, bin=0, sgn=0, dot=0, msg=00, wr_enable=0, led0_sel=0, and clear all internal registers.
REQ-027 SHALL, on rst mid-operation (ABS/CHECK/DIV/EMIT), abort without any wr_enable pulse and keep the outputs at their reset values.

Verification
REQ-028 SHALL cover: mode=00, value=123, frac=0 -> wr pulse 2 cycles after accept; bin=123, sgn=0, dot=0, msg=00.
REQ-029 SHALL cover: value=-12345 (0xCFC7), frac=2 -> two divisions; bin=123, sgn=1, dot=0, msg=00, wr pulse at 36 cycles.
REQ-030 SHALL cover: value=1999, frac=2 -> bin=199, dot=1, sgn=0 at 19 cycles; value=-5, frac=2 -> bin=5, sgn=1, dot=2 at 2 cycles.
REQ-031 SHALL cover: value=300, frac=0 -> msg=11, bin=0; value=-32768, frac=2 -> magnitude 327 after two divisions -> msg=11, sgn=0.
REQ-032 SHALL cover: mode=01 and mode=10 -> msg=01 and msg=10 respectively, bin=0, 2-cycle latency; frac=3 with mode=00 -> msg=11.
REQ-033 SHALL cover: rst asserted during DIV -> no wr pulse, ready=1, outputs zero; req held high while busy -> exactly one wr pulse, then a new accept in IDLE.

Source files
------------

// File: rtl/disp_formatter_if.sv
// CPU-to-display-decoder bus for disp_formatter: request fields in, formatted digits and write strobe out.
interface disp_formatter_if;
    logic        req;
    logic [1:0]  mode;
    logic [15:0] value;
    logic [1:0]  frac;
    logic        ready;
    logic [7:0]  bin;
    logic        sgn;
    logic [1:0]  dot;
    logic [1:0]  msg;
    logic        wr_enable;
    logic        led0_sel;

    modport master (
        output req, mode, value, frac,
        input  ready, bin, sgn, dot, msg, wr_enable, led0_sel
    );

    modport slave (
        input  req, mode, value, frac,
        output ready, bin, sgn, dot, msg, wr_enable, led0_sel
    );
endinterface

// File: rtl/disp_formatter.sv
// Formats a signed, decimal-scaled 16-bit value into an 8-bit magnitude, sign and decimal-point
// position, dividing by 10 (dropping fractional digits) until it fits or no fraction is left.
module disp_formatter (
    input  logic              clk,
    input  logic              rst,
    disp_formatter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_CHECK,
        S_DIV,
        S_EMIT
    } state_e;

    localparam logic [1:0] MSG_NUM = 2'b00;
    localparam logic [1:0] MSG_ERR = 2'b11;

    state_e      state_q;
    logic [1:0]  mode_q;
    logic [1:0]  frac_q;
    logic [15:0] mag_q;
    logic        sgn_int_q;
    logic [3:0]  rem_q;
    logic [3:0]  cnt_q;

    logic        ready_q;
    logic [7:0]  bin_q;
    logic        sgn_q;
    logic [1:0]  dot_q;
    logic [1:0]  msg_q;
    logic        wr_q;

    // One restoring-division step by 10: shift the next dividend bit into the partial remainder.
    logic [4:0]  trial_d;
    logic        fits_d;
    logic [3:0]  rem_d;
    logic        is_num_d;
    logic        need_div_d;
    logic        fits_byte_d;

    always_comb begin
        trial_d     = {rem_q, mag_q[15]};
        fits_d      = (trial_d >= 5'd10);
        rem_d       = fits_d ? (trial_d[3:0] - 4'd10) : trial_d[3:0];
        fits_byte_d = (mag_q <= 16'd255);
        is_num_d    = (mode_q == MSG_NUM) && (frac_q != 2'd3);
        need_div_d  = is_num_d && !fits_byte_d && (frac_q != 2'd0);
    end

    // NOTE: every register, internal state included, is cleared asynchronously so an aborted
    // request can never leak partial results or a late write strobe after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'b00;
            frac_q    <= 2'd0;
            mag_q     <= 16'd0;
            sgn_int_q <= 1'b0;
            rem_q     <= 4'd0;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b1;
            bin_q     <= 8'd0;
            sgn_q     <= 1'b0;
            dot_q     <= 2'd0;
            msg_q     <= MSG_NUM;
            wr_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        mode_q  <= bus.mode;
                        frac_q  <= bus.frac;
                        mag_q   <= bus.value;
                        ready_q <= 1'b0;
                        state_q <= S_ABS;
                    end
                end
                S_ABS: begin
                    // -32768 negates to itself, which is exactly 32768 read as unsigned.
                    mag_q     <= mag_q[15] ? (~mag_q + 16'd1) : mag_q;
                    sgn_int_q <= mag_q[15];
                    state_q   <= S_CHECK;
                end
                S_CHECK: begin
                    if (need_div_d) begin
                        rem_q   <= 4'd0;
                        cnt_q   <= 4'd0;
                        state_q <= S_DIV;
                    end else begin
                        wr_q    <= 1'b1;
                        state_q <= S_EMIT;
                        if (is_num_d && fits_byte_d) begin
                            msg_q <= MSG_NUM;
                            bin_q <= mag_q[7:0];
                            sgn_q <= sgn_int_q;
                            dot_q <= frac_q;
                        end else begin
                            msg_q <= (mode_q != MSG_NUM) ? mode_q : MSG_ERR;
                            bin_q <= 8'd0;
                            sgn_q <= 1'b0;
                            dot_q <= 2'd0;
                        end
                    end
                end
                S_DIV: begin
                    // Dividend shifts out of the top while quotient bits fill in from the bottom.
                    mag_q <= {mag_q[14:0], fits_d};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        frac_q  <= frac_q - 2'd1;
                        state_q <= S_CHECK;
                    end
                end
                S_EMIT: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.bin       = bin_q;
    assign bus.sgn       = sgn_q;
    assign bus.dot       = dot_q;
    assign bus.msg       = msg_q;
    assign bus.wr_enable = wr_q;
    assign bus.led0_sel  = wr_q;

endmodule
